nios_system_dbnc_input_pio: RTL

//  Parametrised Avalon-MM input PIO for board switches and keys, and the successor to the fixed 10-bit switch PIO.

---
 rtl/nios_pio_pkg.sv | 24 ++
 rtl/nios_pio_dbnc_chan.sv | 65 ++++++
 rtl/nios_system_dbnc_input_pio.sv | 134 +++++++++++++
 3 files changed

// File: rtl/nios_pio_pkg.sv
// rtl/nios_pio_pkg.sv - register offsets, edge-mode codes and CTRL field positions for the input PIO
// Purpose: shared constants for nios_system_dbnc_input_pio and its channel sub-module.
// Ports: none (package).
package nios_pio_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_RAW     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_CTRL    = 3'd4;

    typedef enum logic [1:0] {
        EDGE_ANY  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_NONE = 2'b11
    } edge_mode_e;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_DBNC_BIT = 2;
    localparam int CTRL_W        = 3;

endpackage

// File: rtl/nios_pio_dbnc_chan.sv
// rtl/nios_pio_dbnc_chan.sv - one input channel: N-flop synchroniser plus tick-based debouncer
// Purpose: synchronise one raw input and accept a new level only after DBNC_TICKS
//          consecutive mismatching prescaler ticks (or immediately when debounce is off).
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   in_bit_i  in   raw asynchronous input
//   tick_i    in   shared debounce tick, one cycle wide
//   dbnc_en_i in   1 = debounce, 0 = stable follows the synchroniser
//   sync_o    out  synchroniser output
//   stable_o  out  debounced level
module nios_pio_dbnc_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_TICKS  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit_i,
    input  logic tick_i,
    input  logic dbnc_en_i,
    output logic sync_o,
    output logic stable_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [7:0]             cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync_bit;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign sync_o   = sync_bit;
    assign stable_o = stable_q;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (!dbnc_en_i) begin
            // Bypass: any count in progress is discarded.
            stable_d = sync_bit;
            cnt_d    = 8'd0;
        end else if (sync_bit == stable_q) begin
            cnt_d = 8'd0;
        end else if (tick_i) begin
            if (cnt_q == 8'(DBNC_TICKS - 1)) begin
                stable_d = sync_bit;
                cnt_d    = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= 8'd0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_bit_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/nios_system_dbnc_input_pio.sv
// rtl/nios_system_dbnc_input_pio.sv - Avalon-MM input PIO with synchroniser, debounce, edge capture and IRQ
// Purpose: WIDTH debounced inputs with runtime-selectable edge capture, W1C flags and a masked level IRQ.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   address    in   word offset (3 bits)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data (32 bits)
//   in_port    in   raw asynchronous inputs (WIDTH bits)
//   irq        out  |(edge_capture & irq_mask)
//   readdata   out  registered read data, zero-extended
module nios_system_dbnc_input_pio
    import nios_pio_pkg::*;
#(
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 5000,
    parameter int DBNC_TICKS  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq,
    output logic [31:0]      readdata
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]       presc_q, presc_d;
    logic                tick;
    logic [WIDTH-1:0]    sync_vec, stable_vec;
    logic [WIDTH-1:0]    stable_d1_q;
    logic [WIDTH-1:0]    irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]    edge_capture_q, edge_capture_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         readdata_q, readdata_d;
    logic [WIDTH-1:0]    rise, fall, edge_vec;
    logic                wr_en;
    edge_mode_e          mode;

    // Free-running prescaler shared by all channels.
    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        nios_pio_dbnc_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBNC_TICKS  (DBNC_TICKS)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .in_bit_i  (in_port[i]),
            .tick_i    (tick),
            .dbnc_en_i (ctrl_q[CTRL_DBNC_BIT]),
            .sync_o    (sync_vec[i]),
            .stable_o  (stable_vec[i])
        );
    end

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = &{1'b0, writedata[31:WIDTH]};
    end

    assign mode  = edge_mode_e'(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign rise  = stable_vec & ~stable_d1_q;
    assign fall  = ~stable_vec & stable_d1_q;
    assign wr_en = chipselect & ~write_n;

    always_comb begin
        edge_vec = '0;
        case (mode)
            EDGE_ANY:  edge_vec = rise | fall;
            EDGE_RISE: edge_vec = rise;
            EDGE_FALL: edge_vec = fall;
            default:   edge_vec = '0;
        endcase
    end

    always_comb begin
        irq_mask_d     = irq_mask_q;
        ctrl_d         = ctrl_q;
        edge_capture_d = edge_capture_q;
        if (wr_en) begin
            case (address)
                REG_IRQMASK: irq_mask_d = writedata[WIDTH-1:0];
                REG_EDGECAP: edge_capture_d = edge_capture_q & ~writedata[WIDTH-1:0];
                REG_CTRL:    ctrl_d = writedata[CTRL_W-1:0];
                default:     ;
            endcase
        end
        // Set is applied after the clear so a simultaneous new edge is kept.
        edge_capture_d = edge_capture_d | edge_vec;
    end

    always_comb begin
        readdata_d = 32'd0;
        case (address)
            REG_DATA:    readdata_d[WIDTH-1:0]  = stable_vec;
            REG_RAW:     readdata_d[WIDTH-1:0]  = sync_vec;
            REG_IRQMASK: readdata_d[WIDTH-1:0]  = irq_mask_q;
            REG_EDGECAP: readdata_d[WIDTH-1:0]  = edge_capture_q;
            REG_CTRL:    readdata_d[CTRL_W-1:0] = ctrl_q;
            default:     readdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            stable_d1_q    <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            ctrl_q         <= '0;
            readdata_q     <= 32'd0;
        end else begin
            presc_q        <= presc_d;
            stable_d1_q    <= stable_vec;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            ctrl_q         <= ctrl_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule
